csr_file: RTL

Control and status register file for the LoongArch pipeline. It answers the CSR read and write requests issued by the write-back stage, and it holds exception and interrupt state. On exception commit (`wb_ex`) it saves and masks the privilege state. On `ertn` it restores that state. It also supplies the redirect targets to the fetch stage and raises the interrupt-pending flag to the decode stage.

---
 rtl/csr_file.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// csr_file: LoongArch control/status registers, exception/ertn state and interrupt pending.
// Optional timer (TID/TCFG/TVAL/TICLR, IS[11]) is built when CSR_TIMER_EN is defined.
module csr_file #(
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [1:0]  is_sw_q, is_sw_d;
    logic [7:0]  is_hw_q;
    logic        ipi_q;
    logic        ti;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [12:0] is_all;
    logic [31:0] rdata;

    logic we_save;
    assign we_save = csr_we && csr_num[13:2] == 12'hC;

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        is_sw_d  = is_sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        eentry_d = eentry_q;
        if (csr_we && csr_num == 14'h0)
            crmd_d = (csr_wvalue[8:0] & csr_wmask[8:0]) | (crmd_q & ~csr_wmask[8:0]);
        if (ertn_flush)
            crmd_d[2:0] = prmd_q;
        if (wb_ex)
            crmd_d[2:0] = 3'b000;
        if (csr_we && csr_num == 14'h1)
            prmd_d = (csr_wvalue[2:0] & csr_wmask[2:0]) | (prmd_q & ~csr_wmask[2:0]);
        if (wb_ex)
            prmd_d = crmd_q[2:0];
        // bit 10 of ECFG is reserved and must never latch a one
        if (csr_we && csr_num == 14'h4)
            ecfg_d = ((csr_wvalue[12:0] & csr_wmask[12:0]) | (ecfg_q & ~csr_wmask[12:0])) & 13'h1BFF;
        if (csr_we && csr_num == 14'h5)
            is_sw_d = (csr_wvalue[1:0] & csr_wmask[1:0]) | (is_sw_q & ~csr_wmask[1:0]);
        if (csr_we && csr_num == 14'h6)
            era_d = (csr_wvalue & csr_wmask) | (era_q & ~csr_wmask);
        if (csr_we && csr_num == 14'hC)
            eentry_d = (csr_wvalue[31:6] & csr_wmask[31:6]) | (eentry_q & ~csr_wmask[31:6]);
        if (wb_ex) begin
            era_d   = wb_pc;
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
        end
        for (int i = 0; i < 4; i++)
            save_d[i] = (we_save && csr_num[1:0] == 2'(i)) ?
                        (csr_wvalue & csr_wmask) | (save_q[i] & ~csr_wmask) : save_q[i];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= 9'h8;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            ipi_q    <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            eentry_q <= '0;
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= hw_int_in;
            ipi_q    <= ipi_int_in;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            eentry_q <= eentry_d;
            for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
        end
    end

`ifdef CSR_TIMER_EN
    logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d, cnt_q, cnt_d;
    logic        ti_q, ti_d;

    always_comb begin
        tid_d  = (csr_we && csr_num == 14'h40) ? (csr_wvalue & csr_wmask) | (tid_q & ~csr_wmask) : tid_q;
        tcfg_d = (csr_we && csr_num == 14'h41) ? (csr_wvalue & csr_wmask) | (tcfg_q & ~csr_wmask) : tcfg_q;
        cnt_d  = cnt_q;
        ti_d   = ti_q;
        // all-ones is the parked state of a one-shot timer that already expired
        if (csr_we && csr_num == 14'h41 && tcfg_d[0])
            cnt_d = {tcfg_d[31:2], 2'b00};
        else if (tcfg_q[0] && cnt_q != '1)
            cnt_d = (cnt_q == 32'h0 && tcfg_q[1]) ? {tcfg_q[31:2], 2'b00} : cnt_q - 32'h1;
        if (csr_we && csr_num == 14'h44 && csr_wvalue[0] && csr_wmask[0])
            ti_d = 1'b0;
        if (tcfg_q[0] && cnt_q == 32'h0)
            ti_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q  <= TID_INIT;
            tcfg_q <= '0;
            cnt_q  <= '1;
            ti_q   <= 1'b0;
        end else begin
            tid_q  <= tid_d;
            tcfg_q <= tcfg_d;
            cnt_q  <= cnt_d;
            ti_q   <= ti_d;
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    assign is_all = {ipi_q, ti, 1'b0, is_hw_q, is_sw_q};

    always_comb begin
        rdata = '0;
        case (csr_num)
            14'h0:  rdata = {23'h0, crmd_q};
            14'h1:  rdata = {29'h0, prmd_q};
            14'h4:  rdata = {19'h0, ecfg_q};
            14'h5:  rdata = {1'b0, esub_q, ecode_q, 3'b000, is_all};
            14'h6:  rdata = era_q;
            14'hC:  rdata = {eentry_q, 6'h0};
            14'h30: rdata = save_q[0];
            14'h31: rdata = save_q[1];
            14'h32: rdata = save_q[2];
            14'h33: rdata = save_q[3];
`ifdef CSR_TIMER_EN
            14'h40: rdata = tid_q;
            14'h41: rdata = tcfg_q;
            14'h42: rdata = cnt_q;
`endif
            default: rdata = '0;
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'h0;
    assign ex_entry   = {eentry_q, 6'h0};
    assign ertn_entry = era_q;
    assign has_int    = (|(is_all & ecfg_q)) & crmd_q[2];
endmodule
